// File: rtl/rubric_pkg.sv
// Shared types for the rubric scoreboard: run state, ctrl bit positions and
// the credit classification of a single check.
package rubric_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam int unsigned CTRL_MEMWR = 1;
   localparam int unsigned CTRL_MEMRD = 0;

   typedef enum logic [1:0] {
      CreditNone,
      CreditHalf,
      CreditFull
   } credit_e;

   // Ctrl bits only matter for entries flagged chk_ctrl; one matching aspect
   // out of two earns partial credit.
   function automatic credit_e classify(input logic data_ok, input logic ctrl_ok,
                                        input logic chk_ctrl);
      if (data_ok && (!chk_ctrl || ctrl_ok)) return CreditFull;
      if (chk_ctrl && (data_ok || ctrl_ok)) return CreditHalf;
      return CreditNone;
   endfunction

endpackage

// File: rtl/scoreboard_exp_ram.sv
// Expected-result table: synchronous write, combinational read.
module scoreboard_exp_ram #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 35
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rubric_scoreboard.sv
// Checks a stream of observed data_path samples against a loaded table and
// accumulates a weighted half-point score with mismatch reporting and timeout.
module rubric_scoreboard
   import rubric_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned SCORE_W    = 16,
   parameter int unsigned FULL_PTS   = 2,
   parameter int unsigned HALF_PTS   = 1,
   parameter int unsigned GRADE_MULT = 3,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       exp_wr_en,
   input  logic [$clog2(DEPTH)-1:0]   exp_wr_addr,
   input  logic [DATA_W-1:0]          exp_wr_data,
   input  logic [1:0]                 exp_wr_ctrl,
   input  logic                       exp_wr_chk_ctrl,
   input  logic [$clog2(DEPTH+1)-1:0] num_checks,
   input  logic                       start,
   input  logic                       sample_valid,
   input  logic [DATA_W-1:0]          obs_data,
   input  logic [1:0]                 obs_ctrl,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout,
   output logic [SCORE_W-1:0]         score,
   output logic [SCORE_W-1:0]         grade,
   output logic [$clog2(DEPTH+1)-1:0] pass_cnt,
   output logic [$clog2(DEPTH+1)-1:0] fail_cnt,
   output logic                       err_valid,
   output logic [$clog2(DEPTH)-1:0]   err_idx,
   output logic [DATA_W-1:0]          err_obs
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned EW = DATA_W + 3;

   state_e              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       n_q, n_d;
   logic [TW-1:0]       tcnt_q, tcnt_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [CW-1:0]       pass_q, pass_d;
   logic [CW-1:0]       fail_q, fail_d;
   logic                timeout_q, timeout_d;
   logic                err_valid_q, err_valid_d;
   logic [IW-1:0]       err_idx_q, err_idx_d;
   logic [DATA_W-1:0]   err_obs_q, err_obs_d;

   logic [EW-1:0]       rd_entry;
   logic [DATA_W-1:0]   exp_data;
   logic [1:0]          exp_ctrl;
   logic                exp_chk;
   credit_e             credit;
   logic [SCORE_W-1:0]  credit_pts;
   logic [SCORE_W:0]    score_sum;
   logic [CW-1:0]       n_start;

   scoreboard_exp_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_exp_ram (
      .clk   (clk),
      .we    (exp_wr_en && (state_q != StRun)),
      .waddr (exp_wr_addr),
      .wdata ({exp_wr_chk_ctrl, exp_wr_ctrl, exp_wr_data}),
      .raddr (idx_q),
      .rdata (rd_entry)
   );

   assign {exp_chk, exp_ctrl, exp_data} = rd_entry;

   always_comb begin
      credit = classify(obs_data == exp_data, obs_ctrl == exp_ctrl, exp_chk);
      case (credit)
         CreditFull: credit_pts = SCORE_W'(FULL_PTS);
         CreditHalf: credit_pts = SCORE_W'(HALF_PTS);
         default:    credit_pts = '0;
      endcase
      score_sum = {1'b0, score_q} + {1'b0, credit_pts};
      n_start   = (num_checks > CW'(DEPTH)) ? CW'(DEPTH) : num_checks;
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      n_d         = n_q;
      tcnt_d      = tcnt_q;
      score_d     = score_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      timeout_d   = timeout_q;
      err_valid_d = 1'b0;
      err_idx_d   = err_idx_q;
      err_obs_d   = err_obs_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               n_d       = n_start;
               idx_d     = '0;
               tcnt_d    = '0;
               score_d   = '0;
               pass_d    = '0;
               fail_d    = '0;
               timeout_d = 1'b0;
               state_d   = (n_start == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (tcnt_q == TW'(TIMEOUT)) begin
               // Checks never reached count as failures, without err pulses.
               state_d   = StDone;
               timeout_d = 1'b1;
               fail_d    = fail_q + (n_q - CW'(idx_q));
            end else if (sample_valid) begin
               tcnt_d  = '0;
               idx_d   = idx_q + IW'(1);
               score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               if (credit == CreditFull) begin
                  pass_d = pass_q + CW'(1);
               end else begin
                  err_valid_d = 1'b1;
                  err_idx_d   = idx_q;
                  err_obs_d   = obs_data;
                  if (credit == CreditNone) fail_d = fail_q + CW'(1);
               end
               if (CW'(idx_q) + CW'(1) == n_q) state_d = StDone;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         n_q         <= '0;
         tcnt_q      <= '0;
         score_q     <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
         timeout_q   <= 1'b0;
         err_valid_q <= 1'b0;
         err_idx_q   <= '0;
         err_obs_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         n_q         <= n_d;
         tcnt_q      <= tcnt_d;
         score_q     <= score_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         timeout_q   <= timeout_d;
         err_valid_q <= err_valid_d;
         err_idx_q   <= err_idx_d;
         err_obs_q   <= err_obs_d;
      end
   end

   assign busy      = (state_q == StRun);
   assign done      = (state_q == StDone);
   assign timeout   = timeout_q;
   assign score     = score_q;
   assign grade     = SCORE_W'(score_q * GRADE_MULT);
   assign pass_cnt  = pass_q;
   assign fail_cnt  = fail_q;
   assign err_valid = err_valid_q;
   assign err_idx   = err_idx_q;
   assign err_obs   = err_obs_q;

endmodule

// File: tb/tb_rubric_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_rubric_scoreboard;

   localparam int DEPTH   = 32;
   localparam int TIMEOUT = 64;
   localparam int SMAX    = 65535;

   logic        clk = 1'b0;
   logic        reset;
   logic        exp_wr_en;
   logic [4:0]  exp_wr_addr;
   logic [31:0] exp_wr_data;
   logic [1:0]  exp_wr_ctrl;
   logic        exp_wr_chk_ctrl;
   logic [5:0]  num_checks;
   logic        start;
   logic        sample_valid;
   logic [31:0] obs_data;
   logic [1:0]  obs_ctrl;
   logic        busy, done, timeout, err_valid;
   logic [15:0] score, grade;
   logic [5:0]  pass_cnt, fail_cnt;
   logic [4:0]  err_idx;
   logic [31:0] err_obs;

   rubric_scoreboard dut (
      .clk             (clk),
      .reset           (reset),
      .exp_wr_en       (exp_wr_en),
      .exp_wr_addr     (exp_wr_addr),
      .exp_wr_data     (exp_wr_data),
      .exp_wr_ctrl     (exp_wr_ctrl),
      .exp_wr_chk_ctrl (exp_wr_chk_ctrl),
      .num_checks      (num_checks),
      .start           (start),
      .sample_valid    (sample_valid),
      .obs_data        (obs_data),
      .obs_ctrl        (obs_ctrl),
      .busy            (busy),
      .done            (done),
      .timeout         (timeout),
      .score           (score),
      .grade           (grade),
      .pass_cnt        (pass_cnt),
      .fail_cnt        (fail_cnt),
      .err_valid       (err_valid),
      .err_idx         (err_idx),
      .err_obs         (err_obs)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the table as plain arrays plus run bookkeeping.
   logic [31:0] tbl_data [DEPTH];
   logic [1:0]  tbl_ctrl [DEPTH];
   logic        tbl_chk  [DEPTH];
   bit m_run = 0, m_done = 0, m_to = 0, m_err = 0;
   int m_n = 0, m_idx = 0, m_idle = 0, m_score = 0, m_pass = 0, m_fail = 0;
   int m_err_idx = 0;
   logic [31:0] m_err_obs = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_run = 0; m_done = 0; m_to = 0; m_err = 0; m_idx = 0; m_idle = 0;
         m_score = 0; m_pass = 0; m_fail = 0; m_err_idx = 0; m_err_obs = '0;
      end else begin
         bit was_run;
         int pts;
         was_run = m_run;
         m_err = 0;
         if (!m_run) begin
            if (start) begin
               m_n = (int'(num_checks) > DEPTH) ? DEPTH : int'(num_checks);
               m_idx = 0; m_idle = 0; m_score = 0; m_pass = 0; m_fail = 0; m_to = 0;
               m_run  = (m_n != 0);
               m_done = (m_n == 0);
            end
         end else if (m_idle == TIMEOUT) begin
            m_run = 0; m_done = 1; m_to = 1;
            m_fail += m_n - m_idx;
         end else if (sample_valid) begin
            // Points are the number of matching aspects out of two.
            if (!tbl_chk[m_idx]) pts = (obs_data == tbl_data[m_idx]) ? 2 : 0;
            else pts = int'(obs_data == tbl_data[m_idx]) + int'(obs_ctrl == tbl_ctrl[m_idx]);
            m_score = (m_score + pts > SMAX) ? SMAX : m_score + pts;
            if (pts == 2) m_pass++;
            else begin
               m_err = 1; m_err_idx = m_idx; m_err_obs = obs_data;
               if (pts == 0) m_fail++;
            end
            m_idle = 0;
            m_idx++;
            if (m_idx == m_n) begin m_run = 0; m_done = 1; end
         end else begin
            m_idle++;
         end
         if (exp_wr_en && !was_run) begin
            tbl_data[exp_wr_addr] = exp_wr_data;
            tbl_ctrl[exp_wr_addr] = exp_wr_ctrl;
            tbl_chk[exp_wr_addr]  = exp_wr_chk_ctrl;
         end
      end
   end

   bit check_en = 0;
   always @(negedge clk) begin
      if (check_en) begin
         chk("busy", busy, m_run);
         chk("done", done, m_done);
         chk("timeout", timeout, m_to);
         chk("score", score, m_score);
         chk("grade", grade, (m_score * 3) % 65536);
         chk("pass_cnt", pass_cnt, m_pass);
         chk("fail_cnt", fail_cnt, m_fail);
         chk("err_valid", err_valid, m_err);
         if (m_err) begin
            chk("err_idx", err_idx, m_err_idx);
            chk("err_obs", err_obs, m_err_obs);
         end
      end
   end

   int errq[$];
   always @(negedge clk) if (err_valid === 1'b1) errq.push_back(int'(err_idx));

   task automatic load(input int a, input logic [31:0] d, input logic [1:0] c, input logic k);
      exp_wr_en = 1; exp_wr_addr = 5'(a); exp_wr_data = d; exp_wr_ctrl = c; exp_wr_chk_ctrl = k;
      @(negedge clk);
      exp_wr_en = 0;
   endtask

   task automatic do_start(input int n);
      num_checks = 6'(n); start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic feed(input logic [31:0] d, input logic [1:0] c);
      sample_valid = 1; obs_data = d; obs_ctrl = c;
      @(negedge clk);
      sample_valid = 0;
   endtask

   task automatic feed_table(input int first, input int last);
      for (int i = first; i <= last; i++) feed(tbl_data[i], tbl_ctrl[i]);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      chk("wait_done_within_budget", done, 1'b1);
   endtask

   logic [31:0] plan [20];
   initial begin
      plan = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hB, 32'h3, 32'hFFFFFFFE,
               32'h0, 32'h5, 32'h1, 32'hFFFFFFF4, 32'h4D2, 32'hFFFFF8D7, 32'h1, 32'hFFFFFB2C,
               32'h30, 32'h30};
      reset = 1; exp_wr_en = 0; exp_wr_addr = 0; exp_wr_data = 0; exp_wr_ctrl = 0;
      exp_wr_chk_ctrl = 0; num_checks = 0; start = 0; sample_valid = 0; obs_data = 0;
      obs_ctrl = 0;
      @(negedge clk);
      check_en = 1;
      chk("reset_score", score, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      reset = 0;

      for (int i = 0; i < 20; i++)
         load(i, plan[i], (i == 18) ? 2'b10 : (i == 19) ? 2'b01 : 2'b00, (i >= 18));
      for (int i = 20; i < DEPTH; i++) load(i, $urandom, 2'($urandom), 1'($urandom));

      // Run 1: all match; a start pulse and a table write land mid-run.
      errq.delete();
      do_start(20);
      feed_table(0, 5);
      start = 1; exp_wr_en = 1; exp_wr_addr = 0; exp_wr_data = 32'hDEAD;
      feed(tbl_data[6], tbl_ctrl[6]);
      start = 0; exp_wr_en = 0;
      feed_table(7, 19);
      chk("run1_done", done, 1);
      chk("run1_score", score, 40);
      chk("run1_grade", grade, 120);
      chk("run1_pass", pass_cnt, 20);
      chk("run1_fail", fail_cnt, 0);
      chk("run1_err_pulses", errq.size(), 0);
      // Samples while DONE are ignored.
      feed(32'h0, 2'b00);
      chk("done_sample_ignored", score, 40);

      // Run 2: one wrong datum, one wrong ctrl on a ctrl-checked entry.
      errq.delete();
      do_start(20);
      for (int i = 0; i < 20; i++) begin
         if (i == 9) feed(32'hFFFFFFFF, tbl_ctrl[i]);
         else if (i == 18) feed(32'h30, 2'b00);
         else feed(tbl_data[i], tbl_ctrl[i]);
      end
      chk("run2_score", score, 37);
      chk("run2_pass", pass_cnt, 18);
      chk("run2_fail", fail_cnt, 1);
      chk("run2_err_pulses", errq.size(), 2);
      if (errq.size() == 2) begin
         chk("run2_err_idx0", errq[0], 9);
         chk("run2_err_idx1", errq[1], 18);
      end

      // Run 3: stall after five samples.
      do_start(20);
      feed_table(0, 4);
      wait_done(TIMEOUT + 10);
      chk("run3_timeout", timeout, 1);
      chk("run3_score", score, 10);
      chk("run3_fail", fail_cnt, 15);

      // Zero-length run.
      do_start(0);
      chk("zero_done", done, 1);
      chk("zero_score", score, 0);
      chk("zero_timeout", timeout, 0);

      // Reset mid-run, then sample in IDLE, then a clean run.
      do_start(20);
      feed_table(0, 2);
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("midreset_busy", busy, 0);
      chk("midreset_score", score, 0);
      chk("midreset_pass", pass_cnt, 0);
      feed(tbl_data[0], tbl_ctrl[0]);
      chk("idle_sample_ignored", score, 0);
      do_start(20);
      feed_table(0, 19);
      chk("rerun_score", score, 40);

      // Randomized traffic.
      begin
         int stall;
         stall = 0;
         for (int c = 0; c < 6000; c++) begin
            int k;
            k = m_idx % DEPTH;
            reset = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 19) == 0);
            num_checks = 6'($urandom_range(0, 40));
            exp_wr_en = ($urandom_range(0, 9) == 0);
            exp_wr_addr = 5'($urandom);
            exp_wr_data = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
            exp_wr_ctrl = 2'($urandom);
            exp_wr_chk_ctrl = 1'($urandom);
            if (stall > 0) begin
               sample_valid = 0;
               stall--;
            end else begin
               sample_valid = ($urandom_range(0, 9) < 6);
               if ($urandom_range(0, 249) == 0) stall = TIMEOUT + 6;
            end
            obs_data = ($urandom_range(0, 3) != 0) ? tbl_data[k] : $urandom;
            obs_ctrl = $urandom_range(0, 1) ? tbl_ctrl[k] : 2'($urandom);
            @(negedge clk);
         end
         reset = 0; start = 0; exp_wr_en = 0; sample_valid = 0;
      end

      @(negedge clk);
      check_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rubric_scoreboard.md
Name: rubric_scoreboard

Overview:
- Synthesizable, parametrised result checker for data-path bring-up and grading.
- Holds a loadable table of expected ALU results and expected memory-control bits (mem_write, mem_read).
- Compares a stream of observed samples from data_path against the table in order, and accumulates a weighted score in half-point units with partial credit.
- Reports each mismatch, detects a stalled stream by timeout, and presents final score and grade. Sits beside data_path in the bench or on an FPGA debug harness.

Parameters:
- DATA_W, 32, width of expected/observed result.
- DEPTH, 32, max number of checks in the table.
- SCORE_W, 16, width of score/grade outputs (half-point units).
- FULL_PTS, 2, credit for a full match.
- HALF_PTS, 1, partial credit (see Behaviour).
- GRADE_MULT, 3, grade = score * GRADE_MULT.
- TIMEOUT, 64, idle RUN cycles before abort.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- exp_wr_en, in, 1, table write strobe.
- exp_wr_addr, in, $clog2(DEPTH), table entry index.
- exp_wr_data, in, DATA_W, expected result.
- exp_wr_ctrl, in, 2, expected {mem_write, mem_read}.
- exp_wr_chk_ctrl, in, 1, entry also checks ctrl bits.
- num_checks, in, $clog2(DEPTH+1), checks per run, sampled at start.
- start, in, 1, begin run (pulse).
- sample_valid, in, 1, observed sample present this cycle.
- obs_data, in, DATA_W, observed alu_result.
- obs_ctrl, in, 2, observed {mem_write, mem_read}.
- busy, out, 1, state is RUN.
- done, out, 1, state is DONE.
- timeout, out, 1, run ended by timeout.
- score, out, SCORE_W, accumulated half-points.
- grade, out, SCORE_W, score*GRADE_MULT, truncated to SCORE_W.
- pass_cnt, out, $clog2(DEPTH+1), full matches.
- fail_cnt, out, $clog2(DEPTH+1), zero-credit checks incl. timed-out ones.
- err_valid, out, 1, one-cycle mismatch pulse.
- err_idx, out, $clog2(DEPTH), index of mismatching check.
- err_obs, out, DATA_W, observed data of mismatching check.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: state IDLE; busy, done, timeout, score, grade, pass_cnt, fail_cnt, err_valid, err_idx, err_obs all 0. Table contents are not cleared by reset.
- FSM IDLE -> RUN -> DONE:
  - IDLE: start leads to RUN next edge.
  - RUN: start is ignored.
  - DONE: start leads to RUN, clearing score, counters and timeout on the same edge.
- Run setup:
  - num_checks is latched at start and clamped to DEPTH.
  - If num_checks=0, start goes straight to DONE with score 0.
- Table writes: honoured in IDLE/DONE, ignored in RUN. Synchronous write, combinational read at the current index.
- In RUN, each cycle with sample_valid=1 consumes one check at index idx (starts at 0).
- Credit per check:
  - data match and (chk_ctrl=0 or ctrl match): +FULL_PTS, pass_cnt+1.
  - chk_ctrl=1, data mismatch, ctrl match: +HALF_PTS, err pulse.
  - chk_ctrl=1, data match, ctrl mismatch: +HALF_PTS, err pulse.
  - Otherwise: +0, fail_cnt+1, err pulse.
- Outputs are registered: score, counters and err_* update on the edge after acceptance. err_valid is high for exactly that one cycle.
- When the last check is consumed, the same edge moves to DONE. done=1 and final score are visible together.
- Samples in IDLE/DONE are ignored.
- Timeout:
  - A counter clears on start and on every accepted sample, and increments on each RUN cycle without sample_valid.
  - When it reaches TIMEOUT, the next edge goes to DONE with timeout=1.
  - fail_cnt += remaining checks; no err pulses for them.
- Arithmetic: score saturates at 2^SCORE_W-1. grade is combinational from registered score, width SCORE_W, truncated.
- Reset mid-run: returns to IDLE immediately, all outputs 0.

Decomposition:
- Package rubric_pkg:
  - state enum (IDLE/RUN/DONE).
  - ctrl bit indices (CTRL_MEMWR=1, CTRL_MEMRD=0).
  - credit-kind encoding (FULL/HALF/NONE).
- Sub-module scoreboard_exp_ram: DEPTH x (DATA_W+3) table, sync write, async read.

Test Plan:
- Load 20 entries 0x0,0x1,0x2,0x4,0x5,0x7,0x8,0xB,0x3,0xFFFFFFFE,0x0,0x5,0x1,0xFFFFFFF4,0x4D2,0xFFFFF8D7,0x1,0xFFFFFB2C,0x30,0x30; entries 18/19 have chk_ctrl=1 with ctrl 2'b10/2'b01. num_checks=20, feed identical samples back-to-back -> done 1 cycle after the 20th, score=40, grade=120, pass_cnt=20, fail_cnt=0, no err_valid.
- Same table, entry 9 observed 0xFFFFFFFF, entry 18 observed 0x30 with ctrl 2'b00 -> err_valid at idx 9 and idx 18, score=37, pass_cnt=18, fail_cnt=1.
- Feed 5 samples then hold sample_valid=0 for TIMEOUT cycles -> done, timeout=1, score=10, fail_cnt=15.
- num_checks=0, start -> done next cycle, score=0. Table write during RUN leaves the entry unchanged (verify on a later run).
- Assert reset for 1 cycle after 3 samples -> all outputs 0, IDLE. A new start runs cleanly with the old table intact.
- start pulse during RUN and sample_valid in IDLE -> ignored: idx, score and counters unchanged.
